// File: rtl/vga_pkg.sv
// vga_pkg: shared mode codes, default 640x480@60 timing,
// counter-width helper and pipeline bundle types.
package vga_pkg;

  localparam logic [1:0] MODE_FB    = 2'b00;
  localparam logic [1:0] MODE_BARS  = 2'b01;
  localparam logic [1:0] MODE_CHECK = 2'b10;
  localparam logic [1:0] MODE_BLACK = 2'b11;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
  } sync_t;

  typedef struct packed {
    logic       act;
    logic       img;
    logic [1:0] md;
    logic [2:0] bar;
    logic       chk;
  } pix_sel_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v scan counters with raw sync/active flags.
// Ports: vga_clk_25, reset_n (sync, active-low); h, v counters;
// hs_on/vs_on (sync pulse window, polarity-free), active,
// first (position 0,0), eol (last h), eof (last h of last v).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          vga_clk_25,
  input  logic          reset_n,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hs_on,
  output logic          vs_on,
  output logic          active,
  output logic          first,
  output logic          eol,
  output logic          eof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  assign eol = (h == H_LAST);
  assign eof = eol && (v == V_LAST);

  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (eol) begin
      h <= '0;
      v <= eof ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  assign active = (h < H_ACT) && (v < V_ACT);
  assign hs_on  = (h >= HS_BEG) && (h < HS_END);
  assign vs_on  = (v >= VS_BEG) && (v < VS_END);
  assign first  = (h == '0) && (v == '0);

endmodule

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA scan-out with pixel replication, framebuffer
// address generation and read-latency-aligned RGB/sync/de.
// Ports: vga_clk_25, reset_n (sync, active-low), mode, addr (to RAM),
// din (from RAM), hsync, vsync, de, R, G, B, frame_start.
// VGA_PALETTE_EN adds pal_we, pal_idx, pal_data and a palette lookup.
module vga_scan_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int SCALE_LOG2 = 1,
  parameter int PIX_W      = 2,
  parameter int COLOR_W    = 2,
  parameter int ADDR_W     = 17,
  parameter int RD_LATENCY = 1,
  parameter int BAR_SHIFT  = 6
) (
  input  logic               vga_clk_25,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  output logic [ADDR_W-1:0]  addr,
  input  logic [PIX_W-1:0]   din,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               frame_start
`ifdef VGA_PALETTE_EN
  ,
  input  logic                 pal_we,
  input  logic [PIX_W-1:0]     pal_idx,
  input  logic [3*COLOR_W-1:0] pal_data
`endif
);

  localparam int PIPE = RD_LATENCY + 2;
  localparam int HW = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);

  localparam logic [HW-1:0] FB_W = HW'(FB_WIDTH);
  localparam logic [VW-1:0] FB_H = VW'(FB_HEIGHT);
  localparam logic [VW-1:0] S_MASK = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] FB_STEP = ADDR_W'(FB_WIDTH);

  if (longint'(FB_WIDTH) * FB_HEIGHT > (64'd1 << ADDR_W)) begin : g_fb_fit
    $error("framebuffer FB_WIDTH*FB_HEIGHT exceeds ADDR_W");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_rng
    $error("RD_LATENCY must be 1..4");
  end

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          hs_on;
  logic          vs_on;
  logic          active;
  logic          first;
  logic          eol;
  logic          eof;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .vga_clk_25 (vga_clk_25),
    .reset_n    (reset_n),
    .h          (h),
    .v          (v),
    .hs_on      (hs_on),
    .vs_on      (vs_on),
    .active     (active),
    .first      (first),
    .eol        (eol),
    .eof        (eof)
  );

  logic [HW-1:0]     fx;
  logic [VW-1:0]     fy;
  logic              img;
  logic [1:0]        mode_q;
  logic [1:0]        eff_mode;
  logic [ADDR_W-1:0] line_base;

  assign fx  = h >> SCALE_LOG2;
  assign fy  = v >> SCALE_LOG2;
  assign img = (fx < FB_W) && (fy < FB_H);

  // The frame's first pixel already uses the newly sampled mode.
  assign eff_mode = first ? mode : mode_q;

  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      addr      <= '0;
      line_base <= '0;
      mode_q    <= mode;
    end else begin
      if (img) addr <= line_base + ADDR_W'(fx);
      if (first) mode_q <= mode;
      // Advance one framebuffer row after the last replicated line.
      if (eof) line_base <= '0;
      else if (eol && ((v & S_MASK) == S_MASK))
        line_base <= line_base + FB_STEP;
    end
  end

  sync_t    sync_cur;
  pix_sel_t pix_cur;
  sync_t    sync_d [PIPE];
  pix_sel_t pix_d  [RD_LATENCY+1];
  sync_t    so;
  pix_sel_t sel;

  assign sync_cur = '{hs: hs_on, vs: vs_on, act: active, fs: first};
  assign pix_cur  = '{act: active, img: img, md: eff_mode,
                      bar: h[BAR_SHIFT+2:BAR_SHIFT], chk: h[4] ^ v[4]};

  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE; i++) sync_d[i] <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) pix_d[i] <= '0;
    end else begin
      sync_d[0] <= sync_cur;
      for (int i = 1; i < PIPE; i++) sync_d[i] <= sync_d[i-1];
      pix_d[0] <= pix_cur;
      for (int i = 1; i <= RD_LATENCY; i++) pix_d[i] <= pix_d[i-1];
    end
  end

  // Selector stage that lines up with din for the same position.
  assign sel = pix_d[RD_LATENCY];
  assign so  = sync_d[PIPE-1];

  // MSB-aligned resize: truncates low bits or pads zeros below.
  function automatic logic [COLOR_W-1:0] to_chan(
    input logic [PIX_W-1:0] p
  );
    logic [PIX_W+COLOR_W-1:0] w;
    w = {p, {COLOR_W{1'b0}}};
    return w[PIX_W+COLOR_W-1 -: COLOR_W];
  endfunction

  logic [3*COLOR_W-1:0] fb_rgb;
  logic [3*COLOR_W-1:0] rgb_n;

`ifdef VGA_PALETTE_EN
  logic [3*COLOR_W-1:0] pal [2**PIX_W];

  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**PIX_W; i++)
        pal[i] <= {3{to_chan(PIX_W'(i))}};
    end else if (pal_we) begin
      pal[pal_idx] <= pal_data;
    end
  end

  assign fb_rgb = pal[din];
`else
  assign fb_rgb = {3{to_chan(din)}};
`endif

  always_comb begin
    rgb_n = '0;
    if (sel.act) begin
      unique case (sel.md)
        MODE_FB:    if (sel.img) rgb_n = fb_rgb;
        MODE_BARS:  rgb_n = {{COLOR_W{sel.bar[2]}},
                             {COLOR_W{sel.bar[1]}},
                             {COLOR_W{sel.bar[0]}}};
        MODE_CHECK: rgb_n = {3*COLOR_W{sel.chk}};
        default:    rgb_n = '0;
      endcase
    end
  end

  always_ff @(posedge vga_clk_25) begin
    if (!reset_n) {R, G, B} <= '0;
    else          {R, G, B} <= rgb_n;
  end

  assign hsync       = so.hs ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = so.vs ? VSYNC_POL : ~VSYNC_POL;
  assign de          = so.act;
  assign frame_start = so.fs;

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: randomized framebuffer/mode stimulus on a
// reduced timing, checked cycle by cycle against a frame model.
module tb_vga_scan_engine;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 32, VFP = 2, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int FBW = 24, FBH = 12, S = 1;
  localparam int AW = 10, RL = 3, BS = 3;
  localparam int PIPE = RL + 2;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;
  localparam logic [9:0] IDLE = {~HPOL, ~VPOL, 8'h00};
  localparam int PAL_AT = (VA + 1) * HT;

  logic          clk;
  logic          reset_n;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic [1:0]    din;
  logic          hsync, vsync, de, frame_start;
  logic [1:0]    R, G, B;
  logic [9:0]    pins;
`ifdef VGA_PALETTE_EN
  logic       pal_we;
  logic [1:0] pal_idx;
  logic [5:0] pal_data;
  logic [5:0] pal_m [4];
`endif

  vga_scan_engine #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HSYNC_POL (HPOL), .VSYNC_POL (VPOL),
    .FB_WIDTH (FBW), .FB_HEIGHT (FBH), .SCALE_LOG2 (S),
    .PIX_W (2), .COLOR_W (2), .ADDR_W (AW),
    .RD_LATENCY (RL), .BAR_SHIFT (BS)
  ) dut (
    .vga_clk_25  (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .addr        (addr),
    .din         (din),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .R           (R),
    .G           (G),
    .B           (B),
    .frame_start (frame_start)
`ifdef VGA_PALETTE_EN
    ,
    .pal_we      (pal_we),
    .pal_idx     (pal_idx),
    .pal_data    (pal_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Framebuffer RAM: data for addr appears RL cycles later.
  logic [1:0]    mem [1024];
  logic [AW-1:0] a_d [RL];

  always @(posedge clk) begin
    a_d[0] <= addr;
    for (int k = 1; k < RL; k++) a_d[k] <= a_d[k-1];
  end
  assign din  = mem[a_d[RL-1]];
  assign pins = {hsync, vsync, de, frame_start, R, G, B};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  int         n;
  logic [1:0] fmode;
  logic [9:0] a_cur;
  logic [9:0] exp_pins [20000];
  logic [9:0] exp_addr [20000];
  bit         rnd_mode;
  int         force_at;
  logic [1:0] force_val;

  function automatic logic [5:0] fb_pix(input logic [1:0] px);
`ifdef VGA_PALETTE_EN
    return pal_m[px];
`else
    return {px, px, px};
`endif
  endfunction

  // One cycle: check pins/addr, drive inputs, model position n.
  task automatic tick();
    int p, h, v, fx, fy, bar;
    bit act, hs, vs, img;
    logic [5:0] rgb;
    chk($sformatf("pins@%0d", n), pins,
        (n < PIPE) ? IDLE : exp_pins[n-PIPE]);
    chk($sformatf("addr@%0d", n), addr,
        (n == 0) ? 10'd0 : exp_addr[n-1]);
    if (n == force_at) mode = force_val;
    else if (rnd_mode && $urandom_range(0, 699) == 0)
      mode = 2'($urandom_range(0, 3));
`ifdef VGA_PALETTE_EN
    pal_we   = (n == PAL_AT);
    pal_idx  = 2'd2;
    pal_data = 6'h3F;
    if (n == PAL_AT) pal_m[2] = 6'h3F;
`endif
    p   = n % FRAME;
    h   = p % HT;
    v   = p / HT;
    if (p == 0) fmode = mode;
    act = (h < HA) && (v < VA);
    hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
    fx  = h >> S;
    fy  = v >> S;
    img = (fx < FBW) && (fy < FBH);
    if (img) a_cur = 10'((fy * FBW + fx) % (1 << AW));
    exp_addr[n] = a_cur;
    rgb = '0;
    if (act) begin
      case (fmode)
        2'd0: if (img) rgb = fb_pix(mem[a_cur]);
        2'd1: begin
          bar = (h >> BS) & 7;
          rgb = {((bar & 4) != 0) ? 2'd3 : 2'd0,
                 ((bar & 2) != 0) ? 2'd3 : 2'd0,
                 ((bar & 1) != 0) ? 2'd3 : 2'd0};
        end
        2'd2: if ((((h >> 4) ^ (v >> 4)) & 1) != 0) rgb = 6'h3F;
        default: rgb = '0;
      endcase
    end
    exp_pins[n] = {hs ? HPOL : ~HPOL, vs ? VPOL : ~VPOL,
                   act, (p == 0), rgb};
    n++;
  endtask

  task automatic run(input int cnt);
    repeat (cnt) begin
      @(negedge clk);
      tick();
    end
  endtask

  task automatic hold_reset(input int cnt);
    reset_n = 1'b0;
    repeat (cnt) begin
      @(negedge clk);
      chk("rst_pins", pins, IDLE);
      chk("rst_addr", addr, 10'd0);
    end
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    n = 0;
    a_cur = '0;
`ifdef VGA_PALETTE_EN
    for (int i = 0; i < 4; i++) pal_m[i] = {3{2'(i)}};
`endif
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'($urandom);
    mode      = 2'd0;
    rnd_mode  = 1'b0;
    force_at  = FRAME + 10 * HT;
    force_val = 2'd1;
`ifdef VGA_PALETTE_EN
    pal_we   = 1'b0;
    pal_idx  = '0;
    pal_data = '0;
`endif
    hold_reset(5);
    release_reset();
    run(3 * FRAME - 1);
    rnd_mode = 1'b1;
    // Stop mid-line at h=30, v=10 and reset there.
    run(FRAME + 10 * HT + 31);
    hold_reset(3);
    force_at = -1;
    release_reset();
    run(2 * FRAME);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_engine.md
Name: vga_scan_engine

Overview:
Parameterised VGA scan-out engine.
- Generates configurable sync timing and framebuffer read addresses with integer pixel replication.
- Compensates for a configurable memory read latency so that RGB, sync and data-enable leave aligned.
- Sits between the framebuffer RAM read port and the VGA DAC/pins, running entirely in the pixel clock domain.

Parameters:
H_ACTIVE 640 visible pixels per line
H_FP 16 horizontal front porch
H_SYNC 96 hsync pulse width
H_BP 48 horizontal back porch
V_ACTIVE 480 visible lines
V_FP 10 vertical front porch
V_SYNC 2 vsync pulse width
V_BP 33 vertical back porch
HSYNC_POL 0 active level of hsync (0 = active-low)
VSYNC_POL 0 active level of vsync
FB_WIDTH 320 framebuffer width in pixels
FB_HEIGHT 240 framebuffer height in lines
SCALE_LOG2 1 each framebuffer pixel is replicated 2^SCALE_LOG2 times horizontally and vertically
PIX_W 2 framebuffer pixel width
COLOR_W 2 per-channel output width
ADDR_W 17 framebuffer address width
RD_LATENCY 1 cycles from addr to valid din (1..4)
BAR_SHIFT 6 log2 of test-bar width in pixels

Ports:
vga_clk_25 in 1 pixel clock
reset_n in 1 synchronous, active-low reset
mode in 2 00 framebuffer, 01 colour bars, 10 checkerboard, 11 black
addr out ADDR_W framebuffer read address (registered)
din in PIX_W pixel data, valid RD_LATENCY cycles after addr
hsync out 1 horizontal sync
vsync out 1 vertical sync
de out 1 high during active display
R out COLOR_W red
G out COLOR_W green
B out COLOR_W blue
frame_start out 1 one-cycle pulse with the first active pixel of each frame

Behaviour:
Reset (reset_n=0 at a clock edge):
- h, v counters, addr, R/G/B, de and frame_start all go to 0.
- hsync is driven to !HSYNC_POL and vsync to !VSYNC_POL.
- The mode register loads mode.
- Reset mid-line aborts the frame. The first cycle after release is counter position (0,0).

Counters:
- h counts 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters.
- v advances when h wraps, counting 0..V_TOTAL-1, then returns to 0.
- Counter width is the clog2 of the total.

Timing, per counter position:
- Active display is h<H_ACTIVE && v<V_ACTIVE.
- hsync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync uses the same rule with the V_* parameters.

Address generation (no multiplier):
- fx = h>>SCALE_LOG2, fy = v>>SCALE_LOG2.
- Inside the image region (fx<FB_WIDTH && fy<FB_HEIGHT), addr = line_base + fx.
- line_base starts at 0 at v=0. When h wraps, line_base += FB_WIDTH only on lines where (v+1) mod 2^SCALE_LOG2 == 0.
- Outside the image region, addr holds its last value.
- addr wraps modulo 2^ADDR_W. FB_WIDTH*FB_HEIGHT must fit in ADDR_W; this is checked by an elaboration-time assertion.

Pipeline:
- addr is registered one cycle after the counter position.
- din for that position returns RD_LATENCY cycles later.
- R/G/B are registered one cycle after that.
- hsync, vsync, de, frame_start and the region/pattern selectors are delayed through a shift register of the same depth.
- Total latency from counter position to pins is PIPE = RD_LATENCY+2 cycles, identical for all outputs.

Pixel mapping:
- Mode 00, image region: each channel = din zero-extended or truncated (MSB-aligned) to COLOR_W.
- Mode 00, active but outside the image region: black.
- Mode 01: bar = h[BAR_SHIFT+2:BAR_SHIFT]. R/G/B are all-ones when bar bit 2/1/0 is set.
- Mode 10: white if h[4]^v[4], else black.
- Mode 11: black.
- Whenever de=0, R/G/B are 0 regardless of mode.

Mode register:
- mode is sampled only at counter position (0,0), so a change mid-frame takes effect from the next frame.

frame_start:
- Asserted for the cycle in which pixel (0,0) is on the pins.

Optional Feature:
VGA_PALETTE_EN
- With the macro defined, these extra ports exist: pal_we (1), pal_idx (PIX_W), pal_data (3*COLOR_W, packed R,G,B).
- The palette has 2^PIX_W entries, written synchronously on pal_we.
- In mode 00, din indexes the palette; the read is combinational within the final output stage, so latency is unchanged.
- On reset, palette entry i = grey ramp: each channel = i scaled to COLOR_W.
- A palette write takes effect on the next pixel that uses that entry.
- Without the macro, the extra ports are absent and the direct din mapping above applies.

Decomposition:
Package vga_pkg holds:
- mode encoding localparams (MODE_FB, MODE_BARS, MODE_CHECK, MODE_BLACK);
- the default 640x480@60 timing constants;
- a clog2-based function for the total counter widths.

One sub-module, vga_timing_gen:
- holds the h/v counters and raw sync/active/frame-start generation;
- is reusable by other display blocks.

vga_scan_engine itself owns address generation, the delay line and pixel mapping.

Test Plan:
1. Reset held 5 cycles, then released, defaults -> hsync=1, vsync=1, de=0, RGB=0, addr=0 during reset. First hsync low at cycle 656+PIPE, lasting 96 cycles. Line period 800, frame period 420000 cycles.
2. SCALE_LOG2=1, mode 00:
   - addr on lines 0 and 1 = 0,0,1,1,...,319,319.
   - Line 2 starts at 320.
   - The last image line (479) ends at 76799.
   - The next frame starts at 0.
3. RD_LATENCY=3, memory model returning din=addr[1:0]:
   - R/G/B on the pins equal the expected pixel for every position.
   - de rises exactly 5 cycles after h=0 of line 0.
4. mode 00->01 driven at line 100 -> output stays framebuffer until frame_start. Next frame, pixels 0..63 are black, 64..127 blue, 128..191 green.
5. Reset asserted mid-line at h=300, v=50 -> all outputs take reset values on the next edge. After release, addr restarts at 0 and frame_start pulses after PIPE cycles.
6. VGA_PALETTE_EN: write entry 2 = 0x3F, then din=2 in mode 00 -> R=G=B=3. Entry 1 at reset gives R=G=B=1.
